// File: rtl/sar_scan_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : sar_scan_ctrl
// Brief    : Multi-channel scan scheduler driving the SAR start and mux select
// Revision : 1.0 - initial release
// ============================================================================
module sar_scan_ctrl #(
    parameter int WIDTH         = 10,
    parameter int CHANNELS      = 4,
    parameter int CH_W          = $clog2(CHANNELS),
    parameter int SETTLE_CYCLES = 4,
    parameter int PERIOD_W      = 16
) (
    input  logic                clk_i,
    input  logic                rst_i,
    input  logic                enable_i,
    input  logic [CHANNELS-1:0] chan_mask_i,
    input  logic [PERIOD_W-1:0] period_i,
    input  logic                clear_i,
    input  logic                adc_eoc_i,
    input  logic [WIDTH-1:0]    adc_result_i,
    output logic                adc_start_o,
    output logic [CH_W-1:0]     mux_sel_o,
    output logic [WIDTH-1:0]    data_o,
    output logic [CH_W-1:0]     chan_o,
    output logic                valid_o,
    output logic                scan_done_o,
    output logic                overrun_o,
    output logic                busy_o
);

    localparam int SET_W = $clog2(SETTLE_CYCLES + 1);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_SETTLE = 3'd1,
        S_START  = 3'd2,
        S_CONV   = 3'd3,
        S_GAP    = 3'd4
    } state_t;

    state_t                state;
    state_t                state_nx;
    logic [CHANNELS-1:0]   mask;
    logic [PERIOD_W-1:0]   period_cnt;
    logic [PERIOD_W-1:0]   period_dec;
    logic [SET_W-1:0]      settle_cnt;
    logic                  conv_first;
    logic                  expire;
    logic                  overrun_set;
    logic                  scan_req;
    logic [CH_W-1:0]       first_ch;
    logic [CH_W-1:0]       next_ch;
    logic                  has_next;
    logic [CH_W-1:0]       sel_nx;
    logic                  load_scan;
    logic                  load_settle;
    logic                  start_pulse;
    logic                  capture;
    logic                  done;

    // expire means the counter hits zero this cycle, so scans repeat every period_i cycles
    assign period_dec  = (period_cnt == '0) ? '0 : period_cnt - 1'b1;
    assign expire      = (period_dec == '0);
    assign overrun_set = expire && ((state == S_SETTLE) || (state == S_START) || (state == S_CONV));
    assign scan_req    = enable_i && (chan_mask_i != '0);

    always_comb begin
        first_ch = '0;
        for (int i = CHANNELS - 1; i >= 0; i--) begin
            if (chan_mask_i[i]) first_ch = CH_W'(i);
        end
        has_next = 1'b0;
        next_ch  = '0;
        for (int i = CHANNELS - 1; i >= 0; i--) begin
            if (mask[i] && (i > int'(mux_sel_o))) begin
                has_next = 1'b1;
                next_ch  = CH_W'(i);
            end
        end
    end

    always_comb begin
        state_nx    = state;
        sel_nx      = mux_sel_o;
        load_scan   = 1'b0;
        load_settle = 1'b0;
        start_pulse = 1'b0;
        capture     = 1'b0;
        done        = 1'b0;
        case (state)
            S_IDLE: begin
                if (scan_req) begin
                    state_nx    = S_SETTLE;
                    load_scan   = 1'b1;
                    load_settle = 1'b1;
                    sel_nx      = first_ch;
                end
            end
            S_SETTLE: begin
                if (!enable_i)               state_nx = S_IDLE;
                else if (settle_cnt == '0)   state_nx = S_START;
            end
            S_START: begin
                if (!enable_i) begin
                    state_nx = S_IDLE;
                end else if (adc_eoc_i) begin
                    start_pulse = 1'b1;
                    state_nx    = S_CONV;
                end
            end
            S_CONV: begin
                // eoc is still stale in the first CONV cycle, hence conv_first
                if (!conv_first && adc_eoc_i) begin
                    capture = 1'b1;
                    if (!has_next) begin
                        done     = 1'b1;
                        state_nx = enable_i ? S_GAP : S_IDLE;
                    end else if (!enable_i) begin
                        state_nx = S_IDLE;
                    end else begin
                        state_nx    = S_SETTLE;
                        load_settle = 1'b1;
                        sel_nx      = next_ch;
                    end
                end
            end
            S_GAP: begin
                if (!enable_i) begin
                    state_nx = S_IDLE;
                end else if (expire) begin
                    if (scan_req) begin
                        state_nx    = S_SETTLE;
                        load_scan   = 1'b1;
                        load_settle = 1'b1;
                        sel_nx      = first_ch;
                    end else begin
                        state_nx = S_IDLE;
                    end
                end
            end
            default: state_nx = S_IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state       <= S_IDLE;
            mask        <= '0;
            period_cnt  <= '0;
            settle_cnt  <= '0;
            conv_first  <= 1'b0;
            adc_start_o <= 1'b0;
            mux_sel_o   <= '0;
            data_o      <= '0;
            chan_o      <= '0;
            valid_o     <= 1'b0;
            scan_done_o <= 1'b0;
            overrun_o   <= 1'b0;
            busy_o      <= 1'b0;
        end else begin
            state       <= state_nx;
            mux_sel_o   <= sel_nx;
            busy_o      <= (state_nx != S_IDLE);
            adc_start_o <= start_pulse;
            valid_o     <= capture;
            scan_done_o <= done;
            conv_first  <= start_pulse;
            overrun_o   <= overrun_set | (overrun_o & ~clear_i);
            if (capture) begin
                data_o <= adc_result_i;
                chan_o <= mux_sel_o;
            end
            if (load_scan) begin
                mask       <= chan_mask_i;
                period_cnt <= period_i;
            end else if (state != S_IDLE) begin
                period_cnt <= period_dec;
            end
            if (load_settle) begin
                settle_cnt <= SET_W'(SETTLE_CYCLES - 1);
            end else if ((state == S_SETTLE) && (settle_cnt != '0)) begin
                settle_cnt <= settle_cnt - 1'b1;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_sar_scan_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_sar_scan_ctrl
// Brief    : Scoreboard bench for sar_scan_ctrl with a behavioural SAR model
// Revision : 1.0 - initial release
// ============================================================================
module tb_sar_scan_ctrl;

    localparam int WIDTH  = 10;
    localparam int SETTLE = 4;
    localparam int LAT    = WIDTH + 4;

    logic        clk = 1'b0;
    logic        rst_i = 1'b1;
    logic        enable_i = 1'b0;
    logic [3:0]  chan_mask_i = '0;
    logic [15:0] period_i = '0;
    logic        clear_i = 1'b0;
    logic        adc_eoc_i;
    logic [9:0]  adc_result_i;
    logic        adc_start_o;
    logic [1:0]  mux_sel_o;
    logic [9:0]  data_o;
    logic [1:0]  chan_o;
    logic        valid_o;
    logic        scan_done_o;
    logic        overrun_o;
    logic        busy_o;

    sar_scan_ctrl dut (
        .clk_i(clk), .rst_i(rst_i), .enable_i(enable_i), .chan_mask_i(chan_mask_i),
        .period_i(period_i), .clear_i(clear_i), .adc_eoc_i(adc_eoc_i),
        .adc_result_i(adc_result_i), .adc_start_o(adc_start_o), .mux_sel_o(mux_sel_o),
        .data_o(data_o), .chan_o(chan_o), .valid_o(valid_o), .scan_done_o(scan_done_o),
        .overrun_o(overrun_o), .busy_o(busy_o)
    );

    always #5 clk = ~clk;

    typedef struct {
        int         ch;
        logic [9:0] data;
        logic       done;
        int         t;
    } exp_t;

    exp_t       sb[$];
    int         start_cyc[$];
    int         n_checks = 0;
    int         n_errors = 0;
    int         cyc = 0;
    int         n_start = 0;
    int         n_valid = 0;
    int         n_done = 0;
    int         m_prev = -1;
    logic [9:0] res_base = 10'h000;
    logic [9:0] sar_res = 10'h000;
    int         sar_cnt = 0;
    logic       sar_eoc = 1'b1;

    assign adc_eoc_i    = sar_eoc;
    assign adc_result_i = sar_res;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    function automatic int model_next(input logic [3:0] m, input int prev);
        for (int i = 0; i < 4; i++) if (m[i] && i > prev) return i;
        for (int i = 0; i < 4; i++) if (m[i]) return i;
        return 0;
    endfunction

    function automatic logic model_last(input logic [3:0] m, input int ch);
        for (int i = ch + 1; i < 4; i++) if (m[i]) return 1'b0;
        return 1'b1;
    endfunction

    always @(posedge clk) cyc <= cyc + 1;

    // SAR: eoc drops after a start and returns high Width+3 cycles after the start pulse
    always @(posedge clk) begin
        if (rst_i) begin
            sar_eoc <= 1'b1;
            sar_cnt <= 0;
        end else if (adc_start_o) begin
            sar_eoc <= 1'b0;
            sar_cnt <= WIDTH + 2;
            sar_res <= res_base ^ 10'(mux_sel_o);
        end else if (sar_cnt != 0) begin
            sar_cnt <= sar_cnt - 1;
            if (sar_cnt == 1) sar_eoc <= 1'b1;
        end
    end

    always @(negedge clk) begin : monitor
        exp_t e;
        exp_t g;
        int   ch;
        if (adc_start_o) begin
            ch = model_next(chan_mask_i, m_prev);
            m_prev = model_last(chan_mask_i, ch) ? -1 : ch;
            check_eq("start_eoc_high", 32'(adc_eoc_i), 32'd1);
            check_eq("start_mux_sel", 32'(mux_sel_o), 32'(ch));
            e.ch = ch;
            e.data = res_base ^ 10'(ch);
            e.done = model_last(chan_mask_i, ch);
            e.t = cyc;
            sb.push_back(e);
            start_cyc.push_back(cyc);
            n_start++;
        end
        if (valid_o) begin
            n_valid++;
            if (sb.size() == 0) begin
                check_eq("valid_unexpected", 32'd1, 32'd0);
            end else begin
                g = sb.pop_front();
                check_eq("data", 32'(data_o), 32'(g.data));
                check_eq("chan", 32'(chan_o), 32'(g.ch));
                check_eq("scan_done", 32'(scan_done_o), 32'(g.done));
                check_eq("latency", 32'(cyc - g.t), 32'(LAT));
            end
        end
        if (scan_done_o) n_done++;
    end

    task automatic wait_for(input int which, input int budget, input string tag);
        bit hit = 1'b0;
        for (int k = 0; k < budget && !hit; k++) begin
            @(negedge clk);
            case (which)
                0:       hit = adc_start_o;
                1:       hit = valid_o;
                2:       hit = scan_done_o;
                default: hit = overrun_o;
            endcase
        end
        if (!hit) check_eq({tag, "_timeout"}, 32'd0, 32'd1);
    endtask

    task automatic quiesce();
        @(negedge clk);
        enable_i = 1'b0;
        for (int k = 0; k < 100 && busy_o; k++) @(negedge clk);
        repeat (5) @(negedge clk);
        check_eq("idle_busy", 32'(busy_o), 32'd0);
        check_eq("sb_drained", 32'(sb.size()), 32'd0);
        m_prev = -1;
        start_cyc.delete();
    endtask

    initial begin : watchdog
        #300000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin : stim
        int bs, bv, bd, tdone;
        bit seen;

        // reset state
        repeat (3) @(negedge clk);
        check_eq("rst_start", 32'(adc_start_o), 32'd0);
        check_eq("rst_mux", 32'(mux_sel_o), 32'd0);
        check_eq("rst_data", 32'(data_o), 32'd0);
        check_eq("rst_flags", 32'({valid_o, scan_done_o, overrun_o, busy_o}), 32'd0);
        rst_i = 1'b0;
        repeat (2) @(negedge clk);

        // single channel, period 100
        res_base = 10'h2A5; chan_mask_i = 4'b0001; period_i = 16'd100;
        enable_i = 1'b1;
        for (int n = 0; n < 3; n++) wait_for(1, 150, "single_valid");
        check_eq("single_nstart", 32'(start_cyc.size()), 32'd3);
        if (start_cyc.size() >= 3) begin
            check_eq("single_period0", 32'(start_cyc[1] - start_cyc[0]), 32'd100);
            check_eq("single_period1", 32'(start_cyc[2] - start_cyc[1]), 32'd100);
        end
        check_eq("single_overrun", 32'(overrun_o), 32'd0);
        quiesce();

        // mask 1010, period 200
        res_base = 10'h155; chan_mask_i = 4'b1010; period_i = 16'd200;
        bd = n_done; bv = n_valid;
        enable_i = 1'b1;
        for (int n = 0; n < 4; n++) wait_for(1, 250, "m1010_valid");
        repeat (2) @(negedge clk);
        check_eq("m1010_valids", 32'(n_valid - bv), 32'd4);
        check_eq("m1010_dones", 32'(n_done - bd), 32'd2);
        if (start_cyc.size() >= 3) begin
            check_eq("m1010_ch_spacing", 32'(start_cyc[1] - start_cyc[0]), 32'(SETTLE + WIDTH + 5));
            check_eq("m1010_scan_period", 32'(start_cyc[2] - start_cyc[0]), 32'd200);
        end
        check_eq("m1010_overrun", 32'(overrun_o), 32'd0);
        quiesce();

        // overrun: four channels cannot fit in 20 cycles
        res_base = 10'h3C0; chan_mask_i = 4'b1111; period_i = 16'd20;
        bd = n_done;
        enable_i = 1'b1;
        wait_for(3, 100, "ovr_rise");
        check_eq("ovr_set", 32'(overrun_o), 32'd1);
        check_eq("ovr_in_first_scan", 32'(n_done - bd), 32'd0);
        wait_for(2, 200, "ovr_done");
        tdone = cyc;
        clear_i = 1'b1;
        @(negedge clk);
        clear_i = 1'b0;
        check_eq("ovr_cleared", 32'(overrun_o), 32'd0);
        wait_for(0, 20, "ovr_restart");
        check_eq("ovr_restart_delay", 32'(cyc - tdone), 32'(SETTLE + 2));
        wait_for(3, 100, "ovr_rerise");
        check_eq("ovr_reset_again", 32'(overrun_o), 32'd1);
        quiesce();
        clear_i = 1'b1;
        @(negedge clk);
        clear_i = 1'b0;

        // enable drop during CONV of channel 0
        res_base = 10'h0F3; chan_mask_i = 4'b0011; period_i = 16'd200;
        bs = n_start; bv = n_valid;
        enable_i = 1'b1;
        wait_for(0, 30, "drop_conv_start");
        @(negedge clk);
        enable_i = 1'b0;
        wait_for(1, 30, "drop_conv_valid");
        @(negedge clk);
        check_eq("drop_conv_busy", 32'(busy_o), 32'd0);
        repeat (60) @(negedge clk);
        check_eq("drop_conv_starts", 32'(n_start - bs), 32'd1);
        check_eq("drop_conv_valids", 32'(n_valid - bv), 32'd1);
        quiesce();

        // enable drop during SETTLE
        bs = n_start;
        enable_i = 1'b1;
        @(negedge clk);
        check_eq("drop_settle_busy", 32'(busy_o), 32'd1);
        enable_i = 1'b0;
        repeat (40) @(negedge clk);
        check_eq("drop_settle_starts", 32'(n_start - bs), 32'd0);
        check_eq("drop_settle_idle", 32'(busy_o), 32'd0);
        quiesce();

        // empty mask
        chan_mask_i = 4'b0000;
        enable_i = 1'b1;
        seen = 1'b0;
        for (int k = 0; k < 50; k++) begin
            @(negedge clk);
            seen = seen | busy_o | adc_start_o;
        end
        check_eq("empty_mask_activity", 32'(seen), 32'd0);
        quiesce();

        // reset during CONV
        res_base = 10'h1E1; chan_mask_i = 4'b0001; period_i = 16'd100;
        enable_i = 1'b1;
        wait_for(0, 30, "rstconv_start");
        @(negedge clk);
        rst_i = 1'b1;
        @(negedge clk);
        check_eq("rstconv_start", 32'(adc_start_o), 32'd0);
        check_eq("rstconv_mux", 32'(mux_sel_o), 32'd0);
        check_eq("rstconv_data", 32'(data_o), 32'd0);
        check_eq("rstconv_chan", 32'(chan_o), 32'd0);
        check_eq("rstconv_flags", 32'({valid_o, scan_done_o, overrun_o, busy_o}), 32'd0);
        rst_i = 1'b0;
        enable_i = 1'b0;
        sb.delete();
        m_prev = -1;
        bs = n_start;
        repeat (40) @(negedge clk);
        check_eq("rstconv_no_start", 32'(n_start - bs), 32'd0);
        check_eq("final_sb_empty", 32'(sb.size()), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
